// File: rtl/prbs_tx_gen_if.sv
// +--------------------------------------------------------------------------+
// | prbs_tx_gen_if : control/strobe bundle between PRBS source and consumer |
// | Optional PRBS_TX_ERR_INJ_EN adds the error-injection request and count. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface prbs_tx_gen_if #(
  parameter int CNT_W = 9
);
  logic             i_enable;
  logic [1:0]       i_phase;
  logic             o_bit;
  logic             o_valid;
  logic             o_seq_start;
  logic [CNT_W-1:0] o_sym_count;
`ifdef PRBS_TX_ERR_INJ_EN
  logic             i_inject;
  logic [7:0]       o_inj_count;

  modport master (
    input  i_enable, i_phase, i_inject,
    output o_bit, o_valid, o_seq_start, o_sym_count, o_inj_count
  );
  modport slave (
    output i_enable, i_phase, i_inject,
    input  o_bit, o_valid, o_seq_start, o_sym_count, o_inj_count
  );
`else
  modport master (
    input  i_enable, i_phase,
    output o_bit, o_valid, o_seq_start, o_sym_count
  );
  modport slave (
    output i_enable, i_phase,
    input  o_bit, o_valid, o_seq_start, o_sym_count
  );
`endif
endinterface

`default_nettype wire

// File: rtl/prbs_tx_gen.sv
// +--------------------------------------------------------------------------+
// | prbs_tx_gen : PRBS9 (x^9+x^5+1) transmit source, one strobed symbol per  |
// | OS_RATE clocks. Macro PRBS_TX_ERR_INJ_EN enables single-bit error inject.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module prbs_tx_gen #(
  parameter int                  PRBS_LEN = 9,
  parameter logic [PRBS_LEN-1:0] SEED     = 9'h1AA,
  parameter int                  OS_RATE  = 4,
  parameter int                  CNT_W    = 9
) (
  input  wire logic      clk,
  input  wire logic      rst,
  prbs_tx_gen_if.master  bus
);

  localparam int                  OS_W     = (OS_RATE > 1) ? $clog2(OS_RATE) : 1;
  localparam logic [PRBS_LEN-1:0] SEED_EFF = (SEED == '0) ? PRBS_LEN'(1) : SEED;
  localparam logic [CNT_W-1:0]    LAST_SYM = CNT_W'(510);
  localparam logic [OS_W-1:0]     OS_LAST  = OS_W'(OS_RATE - 1);
  localparam int                  MAX_PH   = (OS_RATE - 1 > 3) ? 3 : OS_RATE - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_q;
  logic [PRBS_LEN-1:0] lfsr_q;
  logic [OS_W-1:0]     os_cnt_q;
  logic [CNT_W-1:0]    sym_cnt_q;
  logic [1:0]          phase_q;

  logic [PRBS_LEN-1:0] lfsr_d;
  logic [OS_W-1:0]     os_cnt_d;
  logic [CNT_W-1:0]    sym_cnt_d;
  logic [1:0]          eff_phase;
  logic                os_hit;
  logic                strobe;
  logic                inj_flip;

  assign eff_phase = (int'(bus.i_phase) > MAX_PH) ? 2'(MAX_PH) : bus.i_phase;
  assign lfsr_d    = {lfsr_q[PRBS_LEN-2:0], lfsr_q[PRBS_LEN-1] ^ lfsr_q[4]};
  assign sym_cnt_d = (sym_cnt_q == LAST_SYM) ? '0 : sym_cnt_q + 1'b1;
  assign os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
  assign os_hit    = (int'(os_cnt_q) == int'(phase_q));

  // Exactly the RUN-cycle condition under which a symbol is emitted below.
  assign strobe = (state_q == RUN) && bus.i_enable && (eff_phase == phase_q) &&
                  (lfsr_q != '0) && os_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      lfsr_q          <= SEED_EFF;
      os_cnt_q        <= '0;
      sym_cnt_q       <= '0;
      phase_q         <= '0;
      bus.o_bit       <= 1'b0;
      bus.o_valid     <= 1'b0;
      bus.o_seq_start <= 1'b0;
      bus.o_sym_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bus.o_valid     <= 1'b0;
          bus.o_seq_start <= 1'b0;
          if (bus.i_enable) state_q <= LOAD;
        end
        LOAD: begin
          lfsr_q          <= SEED_EFF;
          os_cnt_q        <= '0;
          sym_cnt_q       <= '0;
          phase_q         <= eff_phase;
          bus.o_valid     <= 1'b0;
          bus.o_seq_start <= 1'b0;
          state_q         <= RUN;
        end
        RUN: begin
          if (!bus.i_enable) begin
            state_q         <= IDLE;
            bus.o_valid     <= 1'b0;
            bus.o_seq_start <= 1'b0;
          end else if (eff_phase != phase_q) begin
            state_q         <= LOAD;
            bus.o_valid     <= 1'b0;
            bus.o_seq_start <= 1'b0;
          end else if (lfsr_q == '0) begin
            // Recovery from an upset into the all-zero lock-up state.
            lfsr_q          <= SEED_EFF;
            bus.o_valid     <= 1'b0;
            bus.o_seq_start <= 1'b0;
          end else begin
            os_cnt_q <= os_cnt_d;
            if (os_hit) begin
              bus.o_valid     <= 1'b1;
              bus.o_bit       <= lfsr_q[PRBS_LEN-1] ^ inj_flip;
              bus.o_sym_count <= sym_cnt_q;
              bus.o_seq_start <= (sym_cnt_q == '0);
              lfsr_q          <= lfsr_d;
              sym_cnt_q       <= sym_cnt_d;
            end else begin
              bus.o_valid     <= 1'b0;
              bus.o_seq_start <= 1'b0;
            end
          end
        end
        default: begin
          state_q         <= IDLE;
          bus.o_valid     <= 1'b0;
          bus.o_seq_start <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRBS_TX_ERR_INJ_EN
  logic       pending_q;
  logic [7:0] inj_cnt_q;

  // A request landing on the consuming strobe merges into the one being served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= 1'b0;
      inj_cnt_q <= 8'd0;
    end else if (strobe && pending_q) begin
      pending_q <= 1'b0;
      if (inj_cnt_q != 8'hFF) inj_cnt_q <= inj_cnt_q + 8'd1;
    end else if (bus.i_inject) begin
      pending_q <= 1'b1;
    end
  end

  assign inj_flip        = pending_q;
  assign bus.o_inj_count = inj_cnt_q;
`else
  assign inj_flip = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prbs_tx_gen.sv
// +--------------------------------------------------------------------------+
// | tb_prbs_tx_gen : scoreboard bench for prbs_tx_gen (OS_RATE=4, SEED=1AA) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_prbs_tx_gen;

  localparam int OS_RATE = 4;

  typedef struct packed {
    logic       b;
    logic       s;
    logic [8:0] c;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   en_cyc;
  int   exp_lat;
  bit   first_pend;
  bit   prev_ok;
  int   prev_cyc;
  bit   sb_on;
  exp_t sb_q[$];
  exp_t last_exp;
  logic [8:0] m_lfsr;
  int   m_idx;
  logic found;

  prbs_tx_gen_if #(.CNT_W(9)) bus ();

  prbs_tx_gen #(
    .PRBS_LEN (9),
    .SEED     (9'h1AA),
    .OS_RATE  (OS_RATE),
    .CNT_W    (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_restart();
    m_lfsr = 9'h1AA;
    m_idx  = 0;
  endtask

  // Independent x^9+x^5+1 reference; inv_idx selects one symbol to invert.
  task automatic push_exp(input int n, input int inv_idx);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = m_lfsr[8] ^ (m_idx == inv_idx);
      e.s = (m_idx == 0);
      e.c = 9'(m_idx);
      sb_q.push_back(e);
      last_exp = e;
      m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
      m_idx  = (m_idx == 510) ? 0 : m_idx + 1;
    end
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_val("timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic start_seq(input int phase, input int n);
    bus.i_phase = 2'(phase);
    bus.i_enable = 1'b1;
    en_cyc     = cyc;
    exp_lat    = 3 + phase;
    first_pend = 1'b1;
    prev_ok    = 1'b0;
    model_restart();
    push_exp(n, -1);
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && sb_on && bus.o_valid) begin
        if (sb_q.size() == 0) begin
          check_val("unexp_strobe", bus.o_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check_val("bit", bus.o_bit, e.b);
          check_val("seq_start", bus.o_seq_start, e.s);
          check_val("sym_count", bus.o_sym_count, e.c);
          if (first_pend) begin
            check_val("latency", cyc - en_cyc, exp_lat);
            first_pend = 1'b0;
          end else if (prev_ok) begin
            check_val("spacing", cyc - prev_cyc, OS_RATE);
          end
          prev_cyc = cyc;
          prev_ok  = 1'b1;
        end
      end
    end
  end

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    n_vec = 0;
    n_err = 0;
    sb_on = 1'b0;
    first_pend = 1'b0;
    prev_ok = 1'b0;
    prev_cyc = 0;
    en_cyc = 0;
    exp_lat = 0;
    bus.i_enable = 1'b0;
    bus.i_phase  = 2'd0;
`ifdef PRBS_TX_ERR_INJ_EN
    bus.i_inject = 1'b0;
`endif
    model_restart();

    repeat (3) @(negedge clk);
    check_val("rst_valid", bus.o_valid, 0);
    check_val("rst_bit", bus.o_bit, 0);
    check_val("rst_seq_start", bus.o_seq_start, 0);
    check_val("rst_sym_count", bus.o_sym_count, 0);
`ifdef PRBS_TX_ERR_INJ_EN
    check_val("rst_inj_count", bus.o_inj_count, 0);
`endif
    rst = 1'b1;
    sb_on = 1'b1;
    repeat (8) @(negedge clk);
    check_val("idle_valid", bus.o_valid, 0);

    // Full period plus wrap: symbols 0..510 then 0..3 again.
    start_seq(0, 515);
    wait_empty(515 * OS_RATE + 40);

    // Ten more strobes, then disable and check hold.
    push_exp(10, -1);
    wait_empty(10 * OS_RATE + 20);
    @(negedge clk);
    bus.i_enable = 1'b0;
    @(negedge clk);
    check_val("dis_valid", bus.o_valid, 0);
    check_val("dis_bit_hold", bus.o_bit, last_exp.b);
    check_val("dis_cnt_hold", bus.o_sym_count, last_exp.c);
    repeat (6) @(negedge clk);
    check_val("dis_cnt_hold2", bus.o_sym_count, last_exp.c);
    start_seq(0, 3);
    wait_empty(40);

    // Enable with phase 2, then change phase mid-run.
    @(negedge clk);
    bus.i_enable = 1'b0;
    repeat (3) @(negedge clk);
    start_seq(2, 5);
    wait_empty(60);
    @(negedge clk);
    start_seq(1, 3);
    wait_empty(40);

    // Asynchronous reset while a strobe is high.
    sb_on = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      found = bus.o_valid;
    end
    check_val("pre_rst_strobe", found, 1);
    rst = 1'b0;
    bus.i_enable = 1'b0;
    #1;
    check_val("arst_valid", bus.o_valid, 0);
    check_val("arst_bit", bus.o_bit, 0);
    check_val("arst_seq_start", bus.o_seq_start, 0);
    check_val("arst_sym_count", bus.o_sym_count, 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb_on = 1'b1;
    repeat (12) @(negedge clk);
    check_val("post_rst_idle", bus.o_valid, 0);
    start_seq(0, 4);
    wait_empty(40);

`ifdef PRBS_TX_ERR_INJ_EN
    @(negedge clk);
    bus.i_enable = 1'b0;
    repeat (3) @(negedge clk);
    start_seq(0, 0);
    push_exp(8, 5);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      #1;
      found = (sb_q.size() == 3);
    end
    check_val("inj_sync", found, 1);
    bus.i_inject = 1'b1;
    @(negedge clk);
    bus.i_inject = 1'b0;
    @(negedge clk);
    bus.i_inject = 1'b1;
    @(negedge clk);
    bus.i_inject = 1'b0;
    wait_empty(40);
    @(negedge clk);
    check_val("inj_count", bus.o_inj_count, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
